// File: rtl/ram_pkg.sv
// Shared definitions for the 1Kx8 scratch RAM: default geometry and the
// clear-sweep state encoding.
package ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

endpackage : ram_pkg

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sweep: zeroes every word once, then hands the write port
// over to the user. State is exported so checkers can bind to it.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              WEn_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  output ram_state_t        state_o
);

  ram_state_t        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter MSB flips exactly as address DEPTH-1 is written, so READY is
  // entered on the same edge that clears the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_o    = WEn_i;
    waddr_o = addr_i;
    wdata_o = data_i;
    busy_o  = 1'b0;
    case (state_q)
      CLEAR: begin
        busy_o  = 1'b1;
        we_o    = 1'b1;
        waddr_o = cnt_q[ADDR_W-1:0];
        wdata_o = '0;
        cnt_d   = cnt_inc;
        if (cnt_inc[ADDR_W]) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign state_o = state_q;

endmodule : ram_clear_ctrl

// File: rtl/ram_1kx8.sv
// Single-port 1024x8 RAM with registered, write-first read data and a
// self-clearing sweep after every reset.
module ram_1kx8
  import ram_pkg::*;
#(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              WEn_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  ram_state_t        ctrl_state;

  ram_clear_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .WEn_i   (WEn_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .we_o    (eff_we),
    .waddr_o (eff_addr),
    .wdata_o (eff_wdata),
    .busy_o  (busy_o),
    .state_o (ctrl_state)
  );

  // Storage carries no reset so it maps onto block RAM; the sweep zeroes it.
  always_ff @(posedge clk_i) begin
    if (eff_we) mem[eff_addr] <= eff_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= '0;
    end else if (ctrl_state == CLEAR) begin
      data_o <= '0;
    end else if (WEn_i) begin
      data_o <= data_i;
    end else begin
      data_o <= mem[addr_i];
    end
  end

endmodule : ram_1kx8

// File: tb/tb_ram_1kx8.sv
// Directed bench for ram_1kx8: sweep length, read/write, boundaries,
// write-first behaviour, accesses during the sweep and asynchronous reset.
module tb_ram_1kx8;

  logic       clk_i;
  logic       rst_ni;
  logic       WEn_i;
  logic [9:0] addr_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       busy_o;

  int vectors;
  int miscompares;

  ram_1kx8 dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .WEn_i  (WEn_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .busy_o (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs change at the falling edge, outputs sampled there too.
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Runs until busy_o drops (bounded); returns busy cycles and data_o faults.
  task automatic wait_sweep(input logic poke, output int n, output int nz);
    n  = 0;
    nz = 0;
    WEn_i  = poke;
    addr_i = 10'd5;
    data_i = 8'hFF;
    while (n < 1100) begin
      cyc();
      if (busy_o !== 1'b1) break;
      n++;
      if (data_o !== 8'h00) nz++;
    end
    n++;
    WEn_i = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    addr_i = a;
    data_i = d;
    WEn_i  = 1'b1;
    cyc();
    WEn_i  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [7:0] exp);
    addr_i = a;
    WEn_i  = 1'b0;
    cyc();
    check(tag, data_o, exp);
  endtask

  initial begin
    int n;
    int nz;
    vectors     = 0;
    miscompares = 0;
    rst_ni = 1'b0;
    WEn_i  = 1'b0;
    addr_i = '0;
    data_i = '0;

    repeat (3) cyc();
    check("rst_data", data_o, 8'h00);
    check("rst_busy", busy_o, 1'b1);

    // Release, then hammer address 5 with 0xFF while the sweep runs.
    rst_ni = 1'b1;
    wait_sweep(1'b1, n, nz);
    check("sweep_len", n, 1024);
    check("sweep_data0", nz, 0);
    check("ready_busy", busy_o, 1'b0);
    rd("addr5_ignored", 10'd5, 8'h00);

    // Basic write/read; write-first shows the data on the write edge.
    addr_i = 10'd100; data_i = 8'd9; WEn_i = 1'b1;
    cyc();
    check("wr100_edge", data_o, 8'd9);
    WEn_i = 1'b0;
    cyc();
    check("rd100_a", data_o, 8'd9);
    cyc();
    check("rd100_b", data_o, 8'd9);

    // Boundaries.
    wr(10'd0, 8'hA5);
    wr(10'd1023, 8'h5A);
    rd("rd_addr0", 10'd0, 8'hA5);
    rd("rd_addr1023", 10'd1023, 8'h5A);
    rd("rd_addr1", 10'd1, 8'h00);
    rd("rd_addr0_again", 10'd0, 8'hA5);

    // Read-during-write.
    wr(10'd200, 8'h11);
    rd("rd200_old", 10'd200, 8'h11);
    addr_i = 10'd200; data_i = 8'h22; WEn_i = 1'b1;
    cyc();
    check("rdw200_edge", data_o, 8'h22);
    WEn_i = 1'b0;
    cyc();
    check("rdw200_next", data_o, 8'h22);

    // Asynchronous reset pulse between clock edges.
    wr(10'd7, 8'h33);
    rd("rd7_before", 10'd7, 8'h33);
    addr_i = 10'd7; data_i = 8'h44; WEn_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_data", data_o, 8'h00);
    check("async_rst_busy", busy_o, 1'b1);
    #1 rst_ni = 1'b1;
    WEn_i = 1'b0;
    wait_sweep(1'b0, n, nz);
    check("sweep2_len", n, 1024);
    check("sweep2_data0", nz, 0);
    rd("rd7_cleared", 10'd7, 8'h00);
    rd("rd100_cleared", 10'd100, 8'h00);
    rd("rd1023_cleared", 10'd1023, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ram_1kx8
